vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_axis_cnt.sv | 66 ++++++
 rtl/vga_timing_gen.sv | 173 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and mode constants for the VGA raster timing generator.
package vga_timing_pkg;

   typedef enum logic [1:0] {
      SEG_SW,
      SEG_BP,
      SEG_ACT,
      SEG_FP
   } seg_e;

   // 800x600 @ 72 Hz
   localparam int unsigned VGA800_H_SW  = 120;
   localparam int unsigned VGA800_H_BP  = 64;
   localparam int unsigned VGA800_H_ACT = 800;
   localparam int unsigned VGA800_H_FP  = 56;
   localparam int unsigned VGA800_V_SW  = 6;
   localparam int unsigned VGA800_V_BP  = 23;
   localparam int unsigned VGA800_V_ACT = 600;
   localparam int unsigned VGA800_V_FP  = 37;
   localparam bit          VGA800_HS_POL = 1'b1;
   localparam bit          VGA800_VS_POL = 1'b1;

   // 640x480 @ 60 Hz
   localparam int unsigned VGA640_H_SW  = 96;
   localparam int unsigned VGA640_H_BP  = 48;
   localparam int unsigned VGA640_H_ACT = 640;
   localparam int unsigned VGA640_H_FP  = 16;
   localparam int unsigned VGA640_V_SW  = 2;
   localparam int unsigned VGA640_V_BP  = 33;
   localparam int unsigned VGA640_V_ACT = 480;
   localparam int unsigned VGA640_V_FP  = 10;
   localparam bit          VGA640_HS_POL = 1'b0;
   localparam bit          VGA640_VS_POL = 1'b0;

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: position counter plus segment state (SW -> BP -> ACT -> FP).
module vga_axis_cnt
   import vga_timing_pkg::*;
#(
   parameter int unsigned SW  = 1,
   parameter int unsigned BP  = 1,
   parameter int unsigned ACT = 1,
   parameter int unsigned FP  = 1,
   parameter int unsigned CW  = $clog2(SW + BP + ACT + FP)
) (
   input  logic          clk_px,
   input  logic          rst_n,
   input  logic          step,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          sync,
   output logic          active
);

   localparam int unsigned   TOT    = SW + BP + ACT + FP;
   localparam logic [CW-1:0] L_LAST = CW'(TOT - 1);
   localparam logic [CW-1:0] L_BP0  = CW'(SW);
   localparam logic [CW-1:0] L_ACT0 = CW'(SW + BP);
   localparam logic [CW-1:0] L_FP0  = CW'(SW + BP + ACT);

   seg_e          r_seg;
   seg_e          w_seg_nxt;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          w_wrap;

   assign w_wrap = step && (r_count == L_LAST);

   // Segment is decided from the next count so sync/active line up with it.
   always_comb begin
      w_count_nxt = r_count;
      w_seg_nxt   = r_seg;
      if (step) begin
         w_count_nxt = w_wrap ? '0 : r_count + 1'b1;
         if (w_count_nxt == '0)
            w_seg_nxt = SEG_SW;
         else if (w_count_nxt == L_BP0)
            w_seg_nxt = SEG_BP;
         else if (w_count_nxt == L_ACT0)
            w_seg_nxt = SEG_ACT;
         else if (w_count_nxt == L_FP0)
            w_seg_nxt = SEG_FP;
      end
   end

   always_ff @(posedge clk_px or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_seg   <= SEG_SW;
      end else begin
         r_count <= w_count_nxt;
         r_seg   <= w_seg_nxt;
      end
   end

   assign count  = r_count;
   assign wrap   = w_wrap;
   assign sync   = (r_seg == SEG_SW);
   assign active = (r_seg == SEG_ACT);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator (sync, enables, coordinates, frame markers).
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_SW   = VGA800_H_SW,
   parameter int unsigned H_BP   = VGA800_H_BP,
   parameter int unsigned H_ACT  = VGA800_H_ACT,
   parameter int unsigned H_FP   = VGA800_H_FP,
   parameter int unsigned V_SW   = VGA800_V_SW,
   parameter int unsigned V_BP   = VGA800_V_BP,
   parameter int unsigned V_ACT  = VGA800_V_ACT,
   parameter int unsigned V_FP   = VGA800_V_FP,
   parameter bit          HS_POL = VGA800_HS_POL,
   parameter bit          VS_POL = VGA800_VS_POL,
   parameter int unsigned XW     = 11,
   parameter int unsigned YW     = 10
) (
   input  logic          clk_px,
   input  logic          rst_n,
   input  logic          en,
   output logic          hs,
   output logic          vs,
   output logic          hen,
   output logic          ven,
   output logic          de,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          sol,
   output logic          sof,
   output logic          eof
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,output logic [15:0]  frame_cnt
`endif
);

   localparam int unsigned H_TOT = H_SW + H_BP + H_ACT + H_FP;
   localparam int unsigned V_TOT = V_SW + V_BP + V_ACT + V_FP;
   localparam int unsigned HCW   = $clog2(H_TOT);
   localparam int unsigned VCW   = $clog2(V_TOT);

   localparam logic [HCW-1:0] L_H_LAST = HCW'(H_TOT - 1);
   localparam logic [HCW-1:0] L_H_OFF  = HCW'(H_SW + H_BP);
   localparam logic [HCW-1:0] L_H_END  = HCW'(H_SW + H_BP + H_ACT);
   localparam logic [VCW-1:0] L_V_LAST = VCW'(V_TOT - 1);
   localparam logic [VCW-1:0] L_V_OFF  = VCW'(V_SW + V_BP);
   localparam logic [VCW-1:0] L_V_END  = VCW'(V_SW + V_BP + V_ACT);
   localparam logic [XW-1:0]  L_X_LAST = XW'(H_ACT - 1);
   localparam logic [YW-1:0]  L_Y_LAST = YW'(V_ACT - 1);

   logic [HCW-1:0] w_hc;
   logic [HCW-1:0] w_hc_nxt;
   logic [HCW-1:0] w_hdiff;
   logic [VCW-1:0] w_vc;
   logic [VCW-1:0] w_vc_nxt;
   logic [VCW-1:0] w_vdiff;
   logic           w_hwrap;
   logic           w_vwrap_unused;
   logic           w_vstep;
   logic           w_hsync;
   logic           w_vsync;
   logic           w_hact;
   logic           w_vact;
   logic           w_hen_nxt;
   logic           w_ven_nxt;
   logic           w_de_nxt;
   logic [XW-1:0]  w_x_nxt;
   logic [YW-1:0]  w_y_nxt;

   logic           r_de;
   logic           r_sol;
   logic           r_sof;
   logic           r_eof;
   logic [XW-1:0]  r_x;
   logic [YW-1:0]  r_y;

   assign w_vstep = en & w_hwrap;

   vga_axis_cnt #(
      .SW  (H_SW),
      .BP  (H_BP),
      .ACT (H_ACT),
      .FP  (H_FP),
      .CW  (HCW)
   ) u_hcnt (
      .clk_px (clk_px),
      .rst_n  (rst_n),
      .step   (en),
      .count  (w_hc),
      .wrap   (w_hwrap),
      .sync   (w_hsync),
      .active (w_hact)
   );

   vga_axis_cnt #(
      .SW  (V_SW),
      .BP  (V_BP),
      .ACT (V_ACT),
      .FP  (V_FP),
      .CW  (VCW)
   ) u_vcnt (
      .clk_px (clk_px),
      .rst_n  (rst_n),
      .step   (w_vstep),
      .count  (w_vc),
      .wrap   (w_vwrap_unused),
      .sync   (w_vsync),
      .active (w_vact)
   );

   // Coordinates and markers decode the counts the axis counters are about to load.
   always_comb begin
      w_hc_nxt = (w_hc == L_H_LAST) ? '0 : w_hc + 1'b1;
      w_vc_nxt = w_vc;
      if (w_hc == L_H_LAST)
         w_vc_nxt = (w_vc == L_V_LAST) ? '0 : w_vc + 1'b1;
      w_hen_nxt = (w_hc_nxt >= L_H_OFF) && (w_hc_nxt < L_H_END);
      w_ven_nxt = (w_vc_nxt >= L_V_OFF) && (w_vc_nxt < L_V_END);
      w_hdiff   = w_hc_nxt - L_H_OFF;
      w_vdiff   = w_vc_nxt - L_V_OFF;
      w_x_nxt   = w_hen_nxt ? XW'(w_hdiff) : '0;
      w_y_nxt   = w_ven_nxt ? YW'(w_vdiff) : '0;
      w_de_nxt  = w_hen_nxt & w_ven_nxt;
   end

   always_ff @(posedge clk_px or negedge rst_n) begin
      if (!rst_n) begin
         r_x   <= '0;
         r_y   <= '0;
         r_de  <= 1'b0;
         r_sol <= 1'b0;
         r_sof <= 1'b0;
         r_eof <= 1'b0;
      end else if (en) begin
         r_x   <= w_x_nxt;
         r_y   <= w_y_nxt;
         r_de  <= w_de_nxt;
         r_sol <= w_de_nxt && (w_x_nxt == '0);
         r_sof <= w_de_nxt && (w_x_nxt == '0) && (w_y_nxt == '0);
         r_eof <= w_de_nxt && (w_x_nxt == L_X_LAST) && (w_y_nxt == L_Y_LAST);
      end else begin
         r_sol <= 1'b0;
         r_sof <= 1'b0;
         r_eof <= 1'b0;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   // Keyed on the registered eof pulse alone, so a pause right after eof cannot drop a frame.
   always_ff @(posedge clk_px or negedge rst_n) begin
      if (!rst_n)
         r_frame_cnt <= '0;
      else if (r_eof)
         r_frame_cnt <= r_frame_cnt + 16'd1;
   end

   assign frame_cnt = r_frame_cnt;
`endif

   assign hs  = w_hsync ? HS_POL : !HS_POL;
   assign vs  = w_vsync ? VS_POL : !VS_POL;
   assign hen = w_hact;
   assign ven = w_vact;
   assign de  = r_de;
   assign x   = r_x;
   assign y   = r_y;
   assign sol = r_sol;
   assign sof = r_sof;
   assign eof = r_eof;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 800x600, a tiny mode and 640x480 side by side.
module tb_vga_timing_gen;

   logic clk;
   logic rst_d, rst_s, rst_v;
   logic en_d, en_s, en_v;

   logic hs_d, vs_d, hen_d, ven_d, de_d, sol_d, sof_d, eof_d;
   logic [10:0] x_d;
   logic [9:0]  y_d;
   logic hs_s, vs_s, hen_s, ven_s, de_s, sol_s, sof_s, eof_s;
   logic [1:0]  x_s;
   logic [1:0]  y_s;
   logic hs_v, vs_v, hen_v, ven_v, de_v, sol_v, sof_v, eof_v;
   logic [9:0]  x_v;
   logic [8:0]  y_v;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] fc_d, fc_s, fc_v;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vga_timing_gen u_def (
      .clk_px (clk), .rst_n (rst_d), .en (en_d),
      .hs (hs_d), .vs (vs_d), .hen (hen_d), .ven (ven_d), .de (de_d),
      .x (x_d), .y (y_d), .sol (sol_d), .sof (sof_d), .eof (eof_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
      ,.frame_cnt (fc_d)
`endif
   );

   vga_timing_gen #(
      .H_SW (2), .H_BP (2), .H_ACT (4), .H_FP (2),
      .V_SW (1), .V_BP (1), .V_ACT (3), .V_FP (1),
      .HS_POL (1'b1), .VS_POL (1'b1), .XW (2), .YW (2)
   ) u_sml (
      .clk_px (clk), .rst_n (rst_s), .en (en_s),
      .hs (hs_s), .vs (vs_s), .hen (hen_s), .ven (ven_s), .de (de_s),
      .x (x_s), .y (y_s), .sol (sol_s), .sof (sof_s), .eof (eof_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
      ,.frame_cnt (fc_s)
`endif
   );

   vga_timing_gen #(
      .H_SW (96), .H_BP (48), .H_ACT (640), .H_FP (16),
      .V_SW (2), .V_BP (33), .V_ACT (480), .V_FP (10),
      .HS_POL (1'b0), .VS_POL (1'b0), .XW (10), .YW (9)
   ) u_640 (
      .clk_px (clk), .rst_n (rst_v), .en (en_v),
      .hs (hs_v), .vs (vs_v), .hen (hen_v), .ven (ven_v), .de (de_v),
      .x (x_v), .y (y_v), .sol (sol_v), .sof (sof_v), .eof (eof_v)
`ifdef VGA_TIMING_FRAME_CNT_EN
      ,.frame_cnt (fc_v)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [63:0] pk(input logic hs, input logic vs, input logic hen,
                                      input logic ven, input logic de, input logic sol,
                                      input logic sof, input logic eof,
                                      input logic [15:0] x, input logic [15:0] y);
      return {24'd0, hs, vs, hen, ven, de, sol, sof, eof, x, y};
   endfunction

   // Expected tiny-mode outputs after k enabled edges; H 2/2/4/2, V 1/1/3/1.
   function automatic logic [63:0] mdl_s(input int k, input bit en_e);
      int hc, vc, xx, yy;
      logic hs, vs, hen, ven, de, sol, sof, eof;
      hc  = k % 10;
      vc  = (k / 10) % 6;
      hs  = (hc < 2);
      vs  = (vc < 1);
      hen = (hc >= 4) && (hc < 8);
      ven = (vc >= 2) && (vc < 5);
      xx  = hen ? hc - 4 : 0;
      yy  = ven ? vc - 2 : 0;
      de  = hen && ven;
      sol = de && (xx == 0) && en_e;
      sof = sol && (yy == 0);
      eof = de && (xx == 3) && (yy == 2) && en_e;
      return pk(hs, vs, hen, ven, de, sol, sof, eof, 16'(xx), 16'(yy));
   endfunction

   // default-mode thread state
   int   kd, pd, hs_fall, hs_rise, vs_fall, hs_hi, gd;
   logic hs_pd, vs_pd, en_ed;
   // tiny-mode thread state
   int   ks, ps, gs, sof0, sof_r1, sof_r2;
   bit   rst_done, pause_done;
   logic en_es;
   // 640 thread state
   int   kv, hs_lo, hs_rv, vs_rv, de_cnt, gv;
   logic hs_pv, vs_pv;

   initial begin
      rst_d = 1'b0; rst_s = 1'b0; rst_v = 1'b0;
      en_d  = 1'b0; en_s  = 1'b0; en_v  = 1'b0;
      #12;
      chk("def_rst", pk(hs_d, vs_d, hen_d, ven_d, de_d, sol_d, sof_d, eof_d, 16'(x_d), 16'(y_d)),
          pk(1, 1, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0));
      chk("sml_rst", pk(hs_s, vs_s, hen_s, ven_s, de_s, sol_s, sof_s, eof_s, 16'(x_s), 16'(y_s)),
          mdl_s(0, 1'b0));
      chk("v640_rst", pk(hs_v, vs_v, hen_v, ven_v, de_v, sol_v, sof_v, eof_v, 16'(x_v), 16'(y_v)),
          pk(0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0));
      @(negedge clk);
      rst_d = 1'b1; rst_s = 1'b1; rst_v = 1'b1;

      fork
         begin : th_def
            kd = 0; pd = 0; gd = 0; hs_hi = 0;
            hs_fall = -1; hs_rise = -1; vs_fall = -1;
            hs_pd = 1'b1; vs_pd = 1'b1;
            while (kd < 30360 && gd < 40000) begin
               gd++;
               en_d = (pd == 0);
               if (pd > 0) pd--;
               en_ed = en_d;
               @(posedge clk); #1;
               if (en_ed) kd++;
               if (en_ed && kd >= 1 && kd <= 1040 && hs_d) hs_hi++;
               if (!hs_d && hs_pd && hs_fall < 0) hs_fall = kd;
               if (hs_d && !hs_pd && hs_rise < 0) hs_rise = kd;
               if (!vs_d && vs_pd && vs_fall < 0) vs_fall = kd;
               hs_pd = hs_d;
               vs_pd = vs_d;
               if (en_ed && kd == 30343)
                  chk("def_pre_de", {63'd0, de_d}, 64'd0);
               if (en_ed && kd == 30344) begin
                  chk("def_first_de", pk(hs_d, vs_d, hen_d, ven_d, de_d, sol_d, sof_d, eof_d,
                      16'(x_d), 16'(y_d)), pk(0, 0, 1, 1, 1, 1, 1, 0, 16'd0, 16'd0));
                  pd = 5;
               end
               if (!en_ed)
                  chk("def_hold", pk(hs_d, vs_d, hen_d, ven_d, de_d, sol_d, sof_d, eof_d,
                      16'(x_d), 16'(y_d)), pk(0, 0, 1, 1, 1, 0, 0, 0, 16'(kd - 30344), 16'd0));
               if (en_ed && kd == 30345)
                  chk("def_resume1", {45'd0, sof_d, sol_d, de_d, 5'd0, x_d},
                      {45'd0, 1'b0, 1'b0, 1'b1, 5'd0, 11'd1});
               if (en_ed && kd == 30354) begin
                  chk("def_x10", {53'd0, x_d}, 64'd10);
                  pd = 5;
               end
               if (en_ed && kd == 30355)
                  chk("def_resume11", {53'd0, x_d}, 64'd11);
            end
            en_d = 1'b1;
            chk("def_done", 64'(kd), 64'd30360);
            chk("def_hs_fall", 64'(hs_fall), 64'd120);
            chk("def_hs_period", 64'(hs_rise), 64'd1040);
            chk("def_hs_high", 64'(hs_hi), 64'd120);
            chk("def_vs_fall", 64'(vs_fall), 64'd6240);
         end

         begin : th_sml
            ks = 0; ps = 0; gs = 0;
            sof0 = -1; sof_r1 = -1; sof_r2 = -1;
            rst_done = 1'b0; pause_done = 1'b0;
            while (ks < 180 && gs < 1000) begin
               gs++;
               en_s = (ps == 0);
               if (ps > 0) ps--;
               en_es = en_s;
               @(posedge clk); #1;
               if (en_es) ks++;
               chk("sml", pk(hs_s, vs_s, hen_s, ven_s, de_s, sol_s, sof_s, eof_s,
                   16'(x_s), 16'(y_s)), mdl_s(ks, en_es));
               if (sof_s) begin
                  if (!rst_done) begin
                     if (sof0 < 0) sof0 = ks;
                  end else if (sof_r1 < 0) sof_r1 = ks;
                  else if (sof_r2 < 0) sof_r2 = ks;
               end
               if (!rst_done && ks == 36) begin
                  #2 rst_s = 1'b0;
                  #1 chk("sml_async_rst", pk(hs_s, vs_s, hen_s, ven_s, de_s, sol_s, sof_s, eof_s,
                         16'(x_s), 16'(y_s)), mdl_s(0, 1'b0));
                  @(negedge clk);
                  rst_s    = 1'b1;
                  ks       = 0;
                  rst_done = 1'b1;
               end
               if (rst_done && !pause_done && ks == 84) begin
                  ps         = 5;
                  pause_done = 1'b1;
               end
            end
            en_s = 1'b1;
            chk("sml_done", 64'(ks), 64'd180);
            chk("sml_sof_first", 64'(sof0), 64'd24);
            chk("sml_sof_after_rst", 64'(sof_r1), 64'd24);
            chk("sml_sof_period", 64'(sof_r2 - sof_r1), 64'd60);
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("sml_frame_cnt", {48'd0, fc_s}, 64'd3);
`endif
         end

         begin : th_640
            kv = 0; gv = 0; hs_lo = 0; de_cnt = 0;
            hs_rv = -1; vs_rv = -1;
            hs_pv = 1'b0; vs_pv = 1'b0;
            en_v = 1'b1;
            while (kv < 28800 && gv < 40000) begin
               gv++;
               @(posedge clk); #1;
               kv++;
               if (kv <= 800 && !hs_v) hs_lo++;
               if (hs_v && !hs_pv && hs_rv < 0) hs_rv = kv;
               if (vs_v && !vs_pv && vs_rv < 0) vs_rv = kv;
               hs_pv = hs_v;
               vs_pv = vs_v;
               if (kv > 28000) de_cnt += int'(de_v);
               if (kv == 28143)
                  chk("v640_pre_de", {63'd0, de_v}, 64'd0);
               if (kv == 28144)
                  chk("v640_first_de", pk(hs_v, vs_v, hen_v, ven_v, de_v, sol_v, sof_v, eof_v,
                      16'(x_v), 16'(y_v)), pk(1, 1, 1, 1, 1, 1, 1, 0, 16'd0, 16'd0));
               if (kv == 28783)
                  chk("v640_last_x", {54'd0, x_v}, 64'd639);
            end
            chk("v640_done", 64'(kv), 64'd28800);
            chk("v640_hs_low", 64'(hs_lo), 64'd96);
            chk("v640_hs_rise", 64'(hs_rv), 64'd96);
            chk("v640_vs_rise", 64'(vs_rv), 64'd1600);
            chk("v640_de_line", 64'(de_cnt), 64'd640);
         end
      join

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
